vga_timing: RTL and testbench



---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_timing_if.sv | 48 ++++
 rtl/sync_delay_line.sv | 36 +++
 rtl/vga_timing.sv | 122 ++++++++++++
 tb/tb_vga_timing.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared raster-timing constants and helpers for the video chain.
// Defaults describe 1024x768@60 on a 65 MHz pixel clock.
package vga_pkg;

    localparam int HCW = 11;
    localparam int VCW = 10;
    localparam int FCW = 16;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    localparam int DEF_H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    typedef struct packed {
        logic hblnk;
        logic vblnk;
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } flags_t;

    function automatic logic sync_level(
        input logic active,
        input logic pol
    );
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel enable in, counters/flags/strobes out.
interface vga_timing_if;
    import vga_pkg::*;

    logic           ce;
    logic [HCW-1:0] hcount_out;
    logic [VCW-1:0] vcount_out;
    logic           hblnk_out;
    logic           vblnk_out;
    logic           hsync_out;
    logic           vsync_out;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_cnt;
    logic           hsync_dly;
    logic           vsync_dly;

    modport master (
        input  ce,
        output hcount_out,
        output vcount_out,
        output hblnk_out,
        output vblnk_out,
        output hsync_out,
        output vsync_out,
        output line_start,
        output frame_start,
        output frame_cnt,
        output hsync_dly,
        output vsync_dly
    );

    modport slave (
        output ce,
        input  hcount_out,
        input  vcount_out,
        input  hblnk_out,
        input  vblnk_out,
        input  hsync_out,
        input  vsync_out,
        input  line_start,
        input  frame_start,
        input  frame_cnt,
        input  hsync_dly,
        input  vsync_dly
    );

endinterface

// File: rtl/sync_delay_line.sv
// Per-clk shift register keeping sync aligned with registered RGB stages.
module sync_delay_line #(
    parameter int                DEPTH   = 1,
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, blanking, syncs, strobes.
// Flags are decoded from next-count values so they register alongside it.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_BLANK  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_START = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);

    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_BLANK  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] VS_START = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam flags_t FLAGS_RST = '{
        hblnk:       1'b0,
        vblnk:       1'b0,
        hsync:       ~HS_POL,
        vsync:       ~VS_POL,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic [HCW-1:0] h_q, h_d;
    logic [VCW-1:0] v_q, v_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    flags_t         flags_q, flags_d;
    logic           h_wrap, v_wrap;
    logic [1:0]     sync_dly;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        fcnt_d = fcnt_q;
        if (bus.ce) begin
            h_d = h_wrap ? '0 : h_q + HCW'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + VCW'(1);
            end
            if (h_wrap && v_wrap) begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    // Holding ce low keeps h_d/v_d steady, so the level flags hold too.
    always_comb begin
        flags_d             = FLAGS_RST;
        flags_d.hblnk       = (h_d >= H_BLANK);
        flags_d.vblnk       = (v_d >= V_BLANK);
        flags_d.hsync       = sync_level(
                                  (h_d >= HS_START) && (h_d <= HS_END),
                                  HS_POL);
        flags_d.vsync       = sync_level(
                                  (v_d >= VS_START) && (v_d <= VS_END),
                                  VS_POL);
        flags_d.line_start  = bus.ce && h_wrap;
        flags_d.frame_start = bus.ce && h_wrap && v_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            fcnt_q  <= '0;
            flags_q <= FLAGS_RST;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            fcnt_q  <= fcnt_d;
            flags_q <= flags_d;
        end
    end

    sync_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   (2),
        .RST_VAL ({~HS_POL, ~VS_POL})
    ) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d   ({flags_q.hsync, flags_q.vsync}),
        .q   (sync_dly)
    );

    assign bus.hcount_out  = h_q;
    assign bus.vcount_out  = v_q;
    assign bus.hblnk_out   = flags_q.hblnk;
    assign bus.vblnk_out   = flags_q.vblnk;
    assign bus.hsync_out   = flags_q.hsync;
    assign bus.vsync_out   = flags_q.vsync;
    assign bus.line_start  = flags_q.line_start;
    assign bus.frame_start = flags_q.frame_start;
    assign bus.frame_cnt   = fcnt_q;
    assign bus.hsync_dly   = sync_dly[1];
    assign bus.vsync_dly   = sync_dly[0];

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 1024x768 timing for line checks, a tiny raster
// (26x13, active-high hsync, 2-clk sync delay) for frame-level behaviour.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    vga_timing_if bus_a ();
    vga_timing_if bus_b ();

    vga_timing dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    vga_timing #(
        .H_ACTIVE   (16),
        .H_FP       (2),
        .H_SYNC     (4),
        .H_BP       (4),
        .V_ACTIVE   (8),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (2),
        .HS_POL     (1'b1),
        .VS_POL     (1'b0),
        .SYNC_DELAY (2)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int n_fail = 0;

    // tiny-raster reference state
    int          bh, bv;
    logic [15:0] bfc;
    bit          bhs, bvs, bs0h, bs1h, bs0v, bs1v;
    int          b_fs_seen, b_ls_seen, b_vs_low, b_hs_act;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_b_model();
        bh   = 0;
        bv   = 0;
        bfc  = 16'h0;
        bhs  = 1'b0;
        bvs  = 1'b1;
        bs0h = 1'b0;
        bs1h = 1'b0;
        bs0v = 1'b1;
        bs1v = 1'b1;
    endtask

    task automatic step_b(input bit c);
        bit line;
        bit frame;
        bus_b.ce = c;
        @(negedge clk);
        line  = c && (bh == 25);
        frame = line && (bv == 12);
        bs1h = bs0h;
        bs0h = bhs;
        bs1v = bs0v;
        bs0v = bvs;
        if (c) begin
            bh = line ? 0 : bh + 1;
            if (line) bv = frame ? 0 : bv + 1;
            if (frame) bfc = bfc + 16'd1;
        end
        bhs = (bh >= 18) && (bh <= 21);
        bvs = !((bv >= 9) && (bv <= 10));
        chk("b_hcount", 32'(bus_b.hcount_out), 32'(bh));
        chk("b_vcount", 32'(bus_b.vcount_out), 32'(bv));
        chk("b_hblnk", 32'(bus_b.hblnk_out), 32'(bh >= 16));
        chk("b_vblnk", 32'(bus_b.vblnk_out), 32'(bv >= 8));
        chk("b_hsync", 32'(bus_b.hsync_out), 32'(bhs));
        chk("b_vsync", 32'(bus_b.vsync_out), 32'(bvs));
        chk("b_line_start", 32'(bus_b.line_start), 32'(line));
        chk("b_frame_start", 32'(bus_b.frame_start), 32'(frame));
        chk("b_frame_cnt", 32'(bus_b.frame_cnt), 32'(bfc));
        chk("b_hsync_dly", 32'(bus_b.hsync_dly), 32'(bs1h));
        chk("b_vsync_dly", 32'(bus_b.vsync_dly), 32'(bs1v));
        b_fs_seen += int'(bus_b.frame_start);
        b_ls_seen += int'(bus_b.line_start);
        b_vs_low  += int'(!bus_b.vsync_out);
        b_hs_act  += int'(bus_b.hsync_out);
    endtask

    initial begin
        int  eh, ev;
        bit  ehs, a_prev_hs;
        int  a_hs_low, a_hb, a_ls;
        int  guard;

        rst_a    = 1'b1;
        rst_b    = 1'b1;
        bus_a.ce = 1'b0;
        bus_b.ce = 1'b0;
        repeat (2) @(negedge clk);

        // reset state, default timing
        chk("a_rst_hcount", 32'(bus_a.hcount_out), 32'd0);
        chk("a_rst_vcount", 32'(bus_a.vcount_out), 32'd0);
        chk("a_rst_hblnk", 32'(bus_a.hblnk_out), 32'd0);
        chk("a_rst_vblnk", 32'(bus_a.vblnk_out), 32'd0);
        chk("a_rst_hsync", 32'(bus_a.hsync_out), 32'd1);
        chk("a_rst_vsync", 32'(bus_a.vsync_out), 32'd1);
        chk("a_rst_line", 32'(bus_a.line_start), 32'd0);
        chk("a_rst_frame", 32'(bus_a.frame_start), 32'd0);
        chk("a_rst_fcnt", 32'(bus_a.frame_cnt), 32'd0);
        chk("a_rst_hs_dly", 32'(bus_a.hsync_dly), 32'd1);
        chk("a_rst_vs_dly", 32'(bus_a.vsync_dly), 32'd1);
        // reset state, tiny raster with active-high hsync
        chk("b_rst_hsync", 32'(bus_b.hsync_out), 32'd0);
        chk("b_rst_vsync", 32'(bus_b.vsync_out), 32'd1);
        chk("b_rst_hs_dly", 32'(bus_b.hsync_dly), 32'd0);
        chk("b_rst_vs_dly", 32'(bus_b.vsync_dly), 32'd1);

        // one full default line
        rst_a     = 1'b0;
        bus_a.ce  = 1'b1;
        a_prev_hs = 1'b1;
        a_hs_low  = 0;
        a_hb      = 0;
        a_ls      = 0;
        for (int i = 1; i <= 1344; i++) begin
            @(negedge clk);
            eh  = i % 1344;
            ev  = (i == 1344) ? 1 : 0;
            ehs = !((eh >= 1048) && (eh <= 1183));
            chk("a_hcount", 32'(bus_a.hcount_out), 32'(eh));
            chk("a_vcount", 32'(bus_a.vcount_out), 32'(ev));
            chk("a_hblnk", 32'(bus_a.hblnk_out), 32'(eh >= 1024));
            chk("a_vblnk", 32'(bus_a.vblnk_out), 32'd0);
            chk("a_hsync", 32'(bus_a.hsync_out), 32'(ehs));
            chk("a_vsync", 32'(bus_a.vsync_out), 32'd1);
            chk("a_line_start", 32'(bus_a.line_start), 32'(i == 1344));
            chk("a_frame_start", 32'(bus_a.frame_start), 32'd0);
            chk("a_hsync_dly", 32'(bus_a.hsync_dly), 32'(a_prev_hs));
            a_prev_hs = ehs;
            a_hs_low += int'(!bus_a.hsync_out);
            a_hb     += int'(bus_a.hblnk_out);
            a_ls     += int'(bus_a.line_start);
        end
        chk("a_hsync_width", 32'(a_hs_low), 32'd136);
        chk("a_hblnk_width", 32'(a_hb), 32'd320);
        chk("a_line_pulses", 32'(a_ls), 32'd1);

        // advance to column 700 of line 1, then reset with ce held high
        repeat (700) @(negedge clk);
        chk("a_mid_hcount", 32'(bus_a.hcount_out), 32'd700);
        chk("a_mid_vcount", 32'(bus_a.vcount_out), 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_mrst_hcount", 32'(bus_a.hcount_out), 32'd0);
        chk("a_mrst_vcount", 32'(bus_a.vcount_out), 32'd0);
        chk("a_mrst_hsync", 32'(bus_a.hsync_out), 32'd1);
        chk("a_mrst_hs_dly", 32'(bus_a.hsync_dly), 32'd1);
        chk("a_mrst_vs_dly", 32'(bus_a.vsync_dly), 32'd1);
        bus_a.ce = 1'b0;

        // tiny raster: one complete frame from reset
        reset_b_model();
        b_fs_seen = 0;
        b_ls_seen = 0;
        b_vs_low  = 0;
        b_hs_act  = 0;
        rst_b = 1'b0;
        step_b(1'b1);
        chk("b_first_ce", 32'(bus_b.hcount_out), 32'd1);
        for (int i = 1; i < 338; i++) step_b(1'b1);
        chk("b_frame_pulses", 32'(b_fs_seen), 32'd1);
        chk("b_line_pulses", 32'(b_ls_seen), 32'd13);
        chk("b_vsync_clks", 32'(b_vs_low), 32'd52);
        chk("b_hsync_clks", 32'(b_hs_act), 32'd52);
        chk("b_fcnt_one", 32'(bus_b.frame_cnt), 32'd1);
        chk("b_at_origin", 32'({bus_b.vcount_out, bus_b.hcount_out}),
            32'd0);

        // alternate ce: 30 advances from (0,0) land on (4,1)
        b_ls_seen = 0;
        for (int i = 0; i < 60; i++) step_b(i % 2 == 0);
        chk("b_tog_hcount", 32'(bus_b.hcount_out), 32'd4);
        chk("b_tog_vcount", 32'(bus_b.vcount_out), 32'd1);
        chk("b_tog_lines", 32'(b_ls_seen), 32'd1);

        // reach (20,9): blanked, both syncs active, then reset
        guard = 0;
        while (!(bh == 20 && bv == 9) && guard < 500) begin
            step_b(1'b1);
            guard++;
        end
        chk("b_reach_mid", 32'(guard < 500), 32'd1);
        rst_b    = 1'b1;
        bus_b.ce = 1'b1;
        @(negedge clk);
        chk("b_mrst_hcount", 32'(bus_b.hcount_out), 32'd0);
        chk("b_mrst_vcount", 32'(bus_b.vcount_out), 32'd0);
        chk("b_mrst_hblnk", 32'(bus_b.hblnk_out), 32'd0);
        chk("b_mrst_vblnk", 32'(bus_b.vblnk_out), 32'd0);
        chk("b_mrst_hsync", 32'(bus_b.hsync_out), 32'd0);
        chk("b_mrst_vsync", 32'(bus_b.vsync_out), 32'd1);
        chk("b_mrst_fcnt", 32'(bus_b.frame_cnt), 32'd0);
        chk("b_mrst_hs_dly", 32'(bus_b.hsync_dly), 32'd0);
        chk("b_mrst_vs_dly", 32'(bus_b.vsync_dly), 32'd1);

        // preload frame counter to 65535 and roll it over
        reset_b_model();
        rst_b = 1'b0;
        step_b(1'b1);
        force dut_b.fcnt_d = 16'hFFFF;
        bfc = 16'hFFFF;
        step_b(1'b0);
        release dut_b.fcnt_d;
        b_fs_seen = 0;
        guard = 0;
        while (b_fs_seen == 0 && guard < 400) begin
            step_b(1'b1);
            guard++;
        end
        chk("b_wrap_reached", 32'(b_fs_seen), 32'd1);
        chk("b_fcnt_wrap", 32'(bus_b.frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
